// File: rtl/mp_display_pkg.sv
// Shared display constants for MiniProject: panel geometry, field widths,
// fill-engine state encoding and the named RGB565 colours used by the game.
package mp_display_pkg;

  localparam int LCD_WIDTH  = 240;
  localparam int LCD_HEIGHT = 320;
  localparam int X_W        = 8;
  localparam int Y_W        = 9;
  localparam int COLOUR_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } fill_state_t;

  localparam logic [COLOUR_W-1:0] BLACK  = 16'h0000;
  localparam logic [COLOUR_W-1:0] RED    = 16'hF800;
  localparam logic [COLOUR_W-1:0] GREEN  = 16'h07E0;
  localparam logic [COLOUR_W-1:0] BLUE   = 16'h001F;
  localparam logic [COLOUR_W-1:0] YELLOW = 16'hFFE0;

endpackage

// File: rtl/rect_fill_engine_if.sv
// Command and pixel-bus signals between the game logic, the fill engine
// and the LT24 driver.
// Handshakes: a command moves on a cycle with cmdValid && cmdReady, and a pixel
// moves on a cycle with pixelWrite && pixelReady; the offering side holds its
// payload stable until that cycle.
interface rect_fill_engine_if;
  import mp_display_pkg::*;

  logic                cmdValid;
  logic                cmdReady;
  logic [X_W-1:0]      cmdX;
  logic [Y_W-1:0]      cmdY;
  logic [X_W-1:0]      cmdWidth;
  logic [Y_W-1:0]      cmdHeight;
  logic [COLOUR_W-1:0] cmdColour;
  logic [X_W-1:0]      xAddr;
  logic [Y_W-1:0]      yAddr;
  logic [COLOUR_W-1:0] pixelData;
  logic                pixelWrite;
  logic                pixelReady;

  modport slave (
    input  cmdValid, cmdX, cmdY, cmdWidth, cmdHeight, cmdColour, pixelReady,
    output cmdReady, xAddr, yAddr, pixelData, pixelWrite
  );

  modport master (
    output cmdValid, cmdX, cmdY, cmdWidth, cmdHeight, cmdColour, pixelReady,
    input  cmdReady, xAddr, yAddr, pixelData, pixelWrite
  );

endinterface

// File: rtl/rect_clip.sv
// Combinational clip of a rectangle origin/size against the panel; produces
// exclusive end coordinates and an empty flag.
module rect_clip
  import mp_display_pkg::*;
#(
  parameter int WIDTH  = LCD_WIDTH,
  parameter int HEIGHT = LCD_HEIGHT
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W:0]   x_end,
  output logic [Y_W:0]   y_end,
  output logic           empty
);

  localparam logic [X_W:0] WIDTH_W  = (X_W+1)'(WIDTH);
  localparam logic [Y_W:0] HEIGHT_W = (Y_W+1)'(HEIGHT);

  // One extra bit on each sum so origin + size cannot wrap.
  logic [X_W:0] x_sum;
  logic [Y_W:0] y_sum;

  assign x_sum = {1'b0, x} + {1'b0, w};
  assign y_sum = {1'b0, y} + {1'b0, h};

  assign x_end = (x_sum > WIDTH_W)  ? WIDTH_W  : x_sum;
  assign y_end = (y_sum > HEIGHT_W) ? HEIGHT_W : y_sum;

  assign empty = (w == '0) || (h == '0) ||
                 ({1'b0, x} >= WIDTH_W) || ({1'b0, y} >= HEIGHT_W);

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: latches one fill command, clips it to the panel and
// streams one pixel write per covered pixel in raster order to the LT24 driver.
module rect_fill_engine
  import mp_display_pkg::*;
#(
  parameter int WIDTH  = LCD_WIDTH,
  parameter int HEIGHT = LCD_HEIGHT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                resetApp,
  rect_fill_engine_if.slave   bus,
  output logic                busy,
  output logic                done,
  output fill_state_t         dbg_state
);

  fill_state_t         state, state_next;
  logic [X_W-1:0]      cmd_x;
  logic [Y_W-1:0]      cmd_y;
  logic [X_W-1:0]      cmd_w;
  logic [Y_W-1:0]      cmd_h;
  logic [COLOUR_W-1:0] cmd_colour;
  logic [X_W:0]        x_end, clip_x_end;
  logic [Y_W:0]        y_end, clip_y_end;
  logic                clip_empty;
  logic [X_W-1:0]      x_addr;
  logic [Y_W-1:0]      y_addr;
  logic [COLOUR_W-1:0] pixel_data;
  logic                cmd_ready, pixel_write, accept, xfer;
  logic [X_W:0]        x_inc;
  logic [Y_W:0]        y_inc;
  logic                last_col, last_row;

  rect_clip #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_clip (
    .x(cmd_x), .y(cmd_y), .w(cmd_w), .h(cmd_h),
    .x_end(clip_x_end), .y_end(clip_y_end), .empty(clip_empty)
  );

  assign x_inc    = {1'b0, x_addr} + 1'b1;
  assign y_inc    = {1'b0, y_addr} + 1'b1;
  assign last_col = (x_inc >= x_end);
  assign last_row = (y_inc >= y_end);
  assign accept   = bus.cmdValid && cmd_ready;
  // A pixel offered while the driver re-initialises is dropped, not counted.
  assign xfer     = pixel_write && bus.pixelReady && !resetApp;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cmd_ready   = 1'b0;
    pixel_write = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !resetApp && !reset;
        if (bus.cmdValid && cmd_ready) state_next = LOAD;
      end
      LOAD: begin
        busy = 1'b1;
        if (resetApp)        state_next = IDLE;
        else if (clip_empty) state_next = DONE;
        else                 state_next = DRAW;
      end
      DRAW: begin
        busy        = 1'b1;
        pixel_write = 1'b1;
        if (resetApp)                          state_next = IDLE;
        else if (xfer && last_col && last_row) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_x      <= '0;
      cmd_y      <= '0;
      cmd_w      <= '0;
      cmd_h      <= '0;
      cmd_colour <= '0;
      x_end      <= '0;
      y_end      <= '0;
      x_addr     <= '0;
      y_addr     <= '0;
      pixel_data <= '0;
    end else begin
      if (accept) begin
        cmd_x      <= bus.cmdX;
        cmd_y      <= bus.cmdY;
        cmd_w      <= bus.cmdWidth;
        cmd_h      <= bus.cmdHeight;
        cmd_colour <= bus.cmdColour;
      end
      if (state == LOAD && !resetApp && !clip_empty) begin
        x_addr     <= cmd_x;
        y_addr     <= cmd_y;
        pixel_data <= cmd_colour;
        x_end      <= clip_x_end;
        y_end      <= clip_y_end;
      end
      // Raster step: wrap to the left edge of the clipped span on the last column.
      if (xfer) begin
        if (!last_col) begin
          x_addr <= x_addr + 1'b1;
        end else begin
          x_addr <= cmd_x;
          y_addr <= y_addr + 1'b1;
        end
      end
    end
  end

  assign bus.cmdReady   = cmd_ready;
  assign bus.pixelWrite = pixel_write;
  assign bus.xAddr      = x_addr;
  assign bus.yAddr      = y_addr;
  assign bus.pixelData  = pixel_data;
  assign dbg_state      = state;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: expected pixels go into a queue when a
// command is issued; a negedge monitor pops and compares each transfer.
module tb_rect_fill_engine;
  import mp_display_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        resetApp;
  logic        busy, done;
  fill_state_t dbg_state;

  rect_fill_engine_if bus ();

  rect_fill_engine dut (
    .clock(clock), .reset(reset), .resetApp(resetApp), .bus(bus),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard state: {x, y, colour}
  logic [32:0] exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;
  int wr_cnt, done_cnt, first_wr_cyc, last_wr_cyc, done_cyc, acc_cyc;
  int ready_mode = 0;
  logic        held_valid = 1'b0;
  logic [32:0] held_pix;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // pixelReady driver: always high, or the 1,0,0 repeating pattern
  initial begin
    bus.pixelReady = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      bus.pixelReady = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    end
  end

  // Monitor
  always @(negedge clock) begin
    logic [32:0] cur, exp;
    cur = {bus.xAddr, bus.yAddr, bus.pixelData};
    if (bus.pixelWrite) begin
      if (held_valid) chk("held_pixel_stable", cur, held_pix);
      if (bus.pixelReady && !resetApp) begin
        held_valid = 1'b0;
        wr_cnt++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", cur, 33'h0);
        end else begin
          exp = exp_q.pop_front();
          vec_cnt++;
          if (cur !== exp) begin
            err_cnt++;
            $display("FAIL pixel: got x=%0d y=%0d d=%h expected x=%0d y=%0d d=%h",
                     cur[32:25], cur[24:16], cur[15:0], exp[32:25], exp[24:16], exp[15:0]);
          end
        end
      end else begin
        held_valid = 1'b1;
        held_pix   = cur;
      end
    end else begin
      held_valid = 1'b0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_in_done", 32'(busy), 32'd1);
    end
  end

  task automatic push_expected(input int x, input int y, input int w, input int h,
                               input logic [15:0] col);
    int xe, ye;
    logic [7:0] xx8;
    logic [8:0] yy9;
    xe = (x + w > LCD_WIDTH)  ? LCD_WIDTH  : x + w;
    ye = (y + h > LCD_HEIGHT) ? LCD_HEIGHT : y + h;
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++) begin
        xx8 = 8'(xx);
        yy9 = 9'(yy);
        exp_q.push_back({xx8, yy9, col});
      end
  endtask

  task automatic send_cmd(input int x, input int y, input int w, input int h,
                          input logic [15:0] col);
    bit accepted;
    accepted = 0;
    @(posedge clock);
    #1;
    bus.cmdValid  = 1'b1;
    bus.cmdX      = 8'(x);
    bus.cmdY      = 9'(y);
    bus.cmdWidth  = 8'(w);
    bus.cmdHeight = 9'(h);
    bus.cmdColour = col;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clock);
      if (bus.cmdReady) begin
        accepted = 1;
        acc_cyc  = cyc;
      end
    end
    if (!accepted) chk("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    bus.cmdValid = 1'b0;
  endtask

  task automatic clear_counters();
    wr_cnt = 0; done_cnt = 0;
    first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
  endtask

  task automatic run_fill(input string name, input int x, input int y, input int w,
                          input int h, input logic [15:0] col, input int exp_writes,
                          input bit ready_high);
    int guard;
    clear_counters();
    push_expected(x, y, w, h, col);
    send_cmd(x, y, w, h, col);
    guard = 0;
    while (done_cnt == 0 && guard < 80000) begin
      @(posedge clock);
      guard++;
    end
    if (done_cnt == 0) chk({name, "_done_timeout"}, 32'd0, 32'd1);
    repeat (3) @(posedge clock);
    chk({name, "_writes"}, 32'(wr_cnt), 32'(exp_writes));
    chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    if (exp_writes > 0) begin
      chk({name, "_done_lat"}, 32'(done_cyc - last_wr_cyc), 32'd1);
      if (ready_high) begin
        chk({name, "_first_lat"}, 32'(first_wr_cyc - acc_cyc), 32'd2);
        chk({name, "_burst"}, 32'(last_wr_cyc - first_wr_cyc), 32'(exp_writes - 1));
      end
    end else begin
      chk({name, "_empty_done_lat"}, 32'(done_cyc - acc_cyc), 32'd2);
    end
    exp_q.delete();
  endtask

  // 4x4 fill interrupted after the 5th pixel by reset or resetApp.
  task automatic run_abort(input bit use_app);
    string name;
    int guard;
    name = use_app ? "abort_app" : "abort_rst";
    clear_counters();
    push_expected(50, 60, 4, 4, YELLOW);
    send_cmd(50, 60, 4, 4, YELLOW);
    guard = 0;
    while (wr_cnt < 5 && guard < 100) begin
      @(posedge clock);
      guard++;
    end
    chk({name, "_reach5"}, 32'(wr_cnt >= 5), 32'd1);
    #1;
    if (use_app) resetApp = 1'b1;
    else         reset    = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk({name, "_pixelwrite"}, 32'(bus.pixelWrite), 32'd0);
    chk({name, "_state"}, 32'(dbg_state), 32'(IDLE));
    chk({name, "_cmdready"}, 32'(bus.cmdReady), use_app ? 32'd0 : 32'd1);
    exp_q.delete();
    if (use_app) begin
      bus.cmdValid = 1'b1;
      repeat (3) @(negedge clock);
      chk("app_blocks_ready", 32'(bus.cmdReady), 32'd0);
      chk("app_blocks_accept", 32'(dbg_state), 32'(IDLE));
      #1;
      bus.cmdValid = 1'b0;
      resetApp     = 1'b0;
    end
    repeat (4) @(posedge clock);
    chk({name, "_no_done"}, 32'(done_cnt), 32'd0);
  endtask

  initial begin
    reset = 1'b1; resetApp = 1'b0;
    bus.cmdValid = 1'b0; bus.cmdX = '0; bus.cmdY = '0;
    bus.cmdWidth = '0; bus.cmdHeight = '0; bus.cmdColour = '0;
    clear_counters();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_cmdready", 32'(bus.cmdReady), 32'd0);
    chk("rst_pixelwrite", 32'(bus.pixelWrite), 32'd0);
    chk("rst_addr", {15'd0, bus.xAddr, bus.yAddr}, 32'd0);
    chk("rst_data", 32'(bus.pixelData), 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("idle_cmdready", 32'(bus.cmdReady), 32'd1);

    run_fill("basic", 10, 20, 3, 2, RED, 6, 1);
    ready_mode = 1;
    run_fill("backpressure", 10, 20, 3, 2, RED, 6, 0);
    ready_mode = 0;
    run_fill("clip_corner", 238, 318, 10, 10, GREEN, 4, 1);
    run_fill("clip_offscreen", 240, 0, 5, 5, GREEN, 0, 1);
    run_fill("zero_width", 5, 5, 0, 7, RED, 0, 1);
    run_fill("full_screen", 0, 0, 240, 320, BLUE, 76800, 1);
    chk("full_last_cyc_set", 32'(last_wr_cyc >= 0), 32'd1);
    run_abort(0);
    run_fill("after_rst", 1, 2, 2, 2, BLACK, 4, 1);
    run_abort(1);
    run_fill("after_app", 100, 300, 3, 3, YELLOW, 9, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
